// File: rtl/sram_responder.sv
// SRAM responder: processor single-cycle port plus a low-priority DMA port.
// The processor always wins; DMA is served only in cycles with sram_EN=0.
module sram_responder #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sram_ADDR,
  input  logic [DATA_W-1:0] sram_DI,
  input  logic              sram_EN,
  input  logic              sram_WE,
  output logic [DATA_W-1:0] sram_DO,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_starved,
  output logic [31:0]       cpu_rd_count,
  output logic [31:0]       cpu_wr_count
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e            state_q;
  logic [CW-1:0]     blk_q;
  logic              ack_q;
  logic              starved_q;
  logic [DATA_W-1:0] do_q;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;

  logic cpu_rd;
  logic cpu_wr;
  logic dma_go;

  assign cpu_rd = sram_EN && !sram_WE;
  assign cpu_wr = sram_EN && sram_WE;
  // DMA may only touch the array in a cycle the processor leaves free
  assign dma_go = dma_req && !sram_EN && (state_q != ACK);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (cpu_rd) rd_cnt_d = rd_cnt_q + 32'd1;
    if (cpu_wr) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (cpu_wr)
      mem[sram_ADDR] <= sram_DI;
    else if (dma_go && dma_we && reset)
      mem[dma_addr] <= dma_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      do_q     <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (cpu_rd) do_q <= mem[sram_ADDR];
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      ack_q     <= 1'b0;
      starved_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      if (dma_go) begin
        if (!dma_we) rdata_q <= mem[dma_addr];
        ack_q     <= 1'b1;
        blk_q     <= '0;
        starved_q <= 1'b0;
        state_q   <= ACK;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (dma_req) begin
              blk_q     <= ONE;
              starved_q <= (LIM == ONE);
              state_q   <= WAIT;
            end
          end
          WAIT: begin
            if (!dma_req) begin
              blk_q     <= '0;
              starved_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              if (blk_q != LIM) blk_q <= blk_q + ONE;
              starved_q <= (blk_q >= LIM - ONE);
            end
          end
          ACK: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sram_DO      = do_q;
  assign dma_ack      = ack_q;
  assign dma_rdata    = rdata_q;
  assign dma_starved  = starved_q;
  assign cpu_rd_count = rd_cnt_q;
  assign cpu_wr_count = wr_cnt_q;

endmodule
